tohost_console_monitor: RTL



---
 rtl/tohost_console_monitor_if.sv | 24 ++
 rtl/tohost_console_monitor.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tohost_console_monitor_if.sv
// Data-memory store/load port and console byte stream of the tohost/console monitor.
// master = CPU MEM stage plus console consumer; slave = monitor device.
interface tohost_console_monitor_if;
    logic        dmem_we;
    logic        dmem_re;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        hit;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    modport master (
        output dmem_we, dmem_re, dmem_addr, dmem_wdata, dmem_wstrb, tx_ready,
        input  dmem_rdata, hit, tx_valid, tx_data
    );

    modport slave (
        input  dmem_we, dmem_re, dmem_addr, dmem_wdata, dmem_wstrb, tx_ready,
        output dmem_rdata, hit, tx_valid, tx_data
    );
endinterface

// File: rtl/tohost_console_monitor.sv
// riscv-tests tohost decoder, console byte FIFO, cycle counter and status register.
// Optional watchdog enabled by defining TOHOST_WATCHDOG_EN.
module tohost_console_monitor #(
    parameter logic [31:0] BASE_ADDR      = 32'h8000_1000,
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                     clk,
    input  logic                     reset,
    tohost_console_monitor_if.slave  bus,
    output logic                     halt,
    output logic                     pass,
    output logic [30:0]              fail_code,
    output logic                     timeout
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTED  = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        halt_d, pass_d, timeout_d;
    logic [30:0] fail_code_d;

    logic [31:0] cycle_q;
    logic        overflow_q;
    logic [31:0] rdata_q;
    logic [7:0]  mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;

    logic        in_run;
    logic        tohost_wr;
    logic        console_wr;
    logic        wd_fire;
    logic        full, empty, pop, push;
    logic [31:0] status;
    logic [31:0] rd_mux;

    assign bus.hit = (bus.dmem_addr[31:4] == BASE_ADDR[31:4]);
    assign in_run  = (state_q == ST_RUN);

    assign tohost_wr  = in_run & bus.dmem_we & bus.hit & (bus.dmem_addr[3:0] == 4'h0)
                      & (bus.dmem_wstrb == 4'hF) & bus.dmem_wdata[0];
    assign console_wr = in_run & bus.dmem_we & bus.hit & (bus.dmem_addr[3:0] == 4'h4)
                      & bus.dmem_wstrb[0];

`ifdef TOHOST_WATCHDOG_EN
    assign wd_fire = in_run & (cycle_q == 32'(TIMEOUT_CYCLES - 1));
`else
    assign wd_fire = 1'b0;
`endif

    // Full when the pointers differ only in their wrap bit
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1])
                 & (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty & bus.tx_ready;
    assign push  = console_wr & (!full | pop);

    assign bus.tx_valid   = !empty;
    assign bus.tx_data    = mem[rd_ptr_q[AW-1:0]];
    assign bus.dmem_rdata = rdata_q;

    assign status = {28'd0, overflow_q, full, empty, halt};

    always_comb begin
        rd_mux = 32'd0;
        case (bus.dmem_addr[3:0])
            4'h8:    rd_mux = status;
            4'hC:    rd_mux = cycle_q;
            default: rd_mux = 32'd0;
        endcase
    end

    // Next-state and result decode; a tohost write outranks the watchdog
    always_comb begin
        state_d     = state_q;
        halt_d      = halt;
        pass_d      = pass;
        fail_code_d = fail_code;
        timeout_d   = timeout;
        case (state_q)
            ST_RUN: begin
                if (tohost_wr) begin
                    state_d     = ST_HALTED;
                    halt_d      = 1'b1;
                    fail_code_d = bus.dmem_wdata[31:1];
                    pass_d      = (bus.dmem_wdata[31:1] == 31'd0);
                    timeout_d   = 1'b0;
                end else if (wd_fire) begin
                    state_d     = ST_TIMEOUT;
                    halt_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_code_d = 31'h7FFF_FFFF;
                    timeout_d   = 1'b1;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            halt      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= 31'd0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            halt      <= halt_d;
            pass      <= pass_d;
            fail_code <= fail_code_d;
            timeout   <= timeout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q    <= 32'd0;
            overflow_q <= 1'b0;
            rdata_q    <= 32'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            if (in_run) cycle_q <= cycle_q + 32'd1;
            if (console_wr && !push) overflow_q <= 1'b1;
            if (bus.dmem_re) rdata_q <= bus.hit ? rd_mux : 32'd0;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Storage carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= bus.dmem_wdata[7:0];
    end

endmodule
